regfile_wb_buffer: RTL and testbench
====================================

Name: regfile_wb_buffer

Overview:
Write-back buffer directly upstream of the register file's bit-cell array. It accepts write-back requests (register index + data) over a valid/ready handshake and queues them in order. It drains at most one entry per cycle into the array as a one-hot row WriteEnable plus a shared D data bus. It also supplies youngest-match read bypass for both read ports so queued but uncommitted writes stay visible to readers.

Parameters:
DATA_W, 16, register width (bits per row of bit cells)
NREG, 16, number of registers (one-hot write-enable width)
DEPTH, 4, queue entries (power of two, >=2)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
wr_valid  input  1  write-back request present
wr_ready  output  1  buffer can accept request this cycle
wr_reg  input  log2(NREG)  destination register index
wr_data  input  DATA_W  write-back data
rf_stall  input  1  when high, no entry commits this cycle
rf_wen  output  NREG  one-hot row WriteEnable to register file
rf_wdata  output  DATA_W  data to every bit cell D input
rd_reg1  input  log2(NREG)  read port 1 index
rd_reg2  input  log2(NREG)  read port 2 index
rd_hit1  output  1  port 1 index matches a queued entry
rd_data1  output  DATA_W  youngest matching queued data for port 1, else 0
rd_hit2  output  1  port 2 equivalent
rd_data2  output  DATA_W  port 2 equivalent
count  output  log2(DEPTH)+1  current occupancy

Behaviour:
- Reset (rst=0, async): head/tail pointers=0, count=0, all valid bits cleared. rf_wen=0 immediately. rd_hit1/2=0, rd_data1/2=0, wr_ready=1.
- Accept condition: wr_valid && wr_ready at the rising edge. wr_ready = (count != DEPTH). No push-on-full even when a pop happens the same cycle.
- Register 0 is hardwired zero. An accepted request with wr_reg==0 is consumed (handshake completes) but not enqueued. count is unchanged.
- Enqueue writes {wr_reg, wr_data} at tail. Tail increments modulo DEPTH; pointers wrap with no gap.
- Commit is combinational from head: rf_wen = (count!=0 && !rf_stall) ? onehot(head.reg) : 0. rf_wdata = head.data (0 when empty). Pop occurs on the same edge at which the array captures.
- Latency with an empty queue and no stall: request accepted at edge N, rf_wen asserted during cycle N+1, value stored in the array at edge N+1.
- Simultaneous push and pop (count between 1 and DEPTH-1): count unchanged; both pointers advance.
- Ordering: strict FIFO. Two writes to the same register commit oldest first.
- Bypass is combinational over valid entries only; the same-cycle incoming request is not searched. The youngest (closest to tail) match wins. rd_regX==0 never hits. An entry popping this cycle still hits during this cycle.
- rf_wen is guaranteed one-hot or zero, and bit 0 is never set.
- rf_stall has no effect on acceptance except via count.

Decomposition:
- Shared package regfile_pkg holds: DATA_W, NREG, REG_IDX_W=$clog2(NREG), and typedef struct wb_entry_t {reg_idx, data}.
- One natural sub-module: wb_onehot_dec (index -> NREG one-hot with enable). It is shared in the codebase with the register file's read-enable decoding.
- The queue and the bypass priority search stay in the top module.

Test Plan:
- Reset: hold rst=0 with wr_valid=1 -> wr_ready=1, count=0, rf_wen=0x0000, rd_hit1=rd_hit2=0. Release reset; no stray commit.
- Single write: wr_reg=3, wr_data=0xBEEF accepted at edge N, rf_stall=0 -> cycle N+1 rf_wen=0x0008, rf_wdata=0xBEEF. count returns to 0 after edge N+1.
- Fill/full: rf_stall=1, push R1..R4 with 0x0001..0x0004 -> count=4, wr_ready=0, 5th request stalls. Drop rf_stall -> rf_wen 0x0002,0x0004,0x0008,0x0010 on consecutive cycles, then 0.
- Bypass priority: rf_stall=1, push R5=0x1111 then R5=0x2222. rd_reg1=5 -> rd_hit1=1, rd_data1=0x2222. rd_reg2=6 -> rd_hit2=0, rd_data2=0x0000.
- R0 drop: push wr_reg=0, data 0xFFFF -> handshake completes, count unchanged, rf_wen bit0 never set, rd_reg1=0 -> rd_hit1=0.
- Reset mid-drain: 3 entries queued and draining, assert rst mid-cycle -> rf_wen=0 with no clock edge. After release: count=0, first new write commits normally.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file widths and the write-back entry type.
package regfile_pkg;
  localparam int DATA_W    = 16;
  localparam int NREG      = 16;
  localparam int REG_IDX_W = $clog2(NREG);
  typedef struct packed {
    logic [REG_IDX_W-1:0] reg_idx;
    logic [DATA_W-1:0]    data;
  } wb_entry_t;
endpackage

// File: rtl/wb_onehot_dec.sv
// wb_onehot_dec: index to one-hot row select, all zero when en is low.
//   en     - decode enable
//   idx    - row index
//   onehot - one-hot row select
module wb_onehot_dec #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic         en,
  input  logic [W-1:0] idx,
  output logic [N-1:0] onehot
);
  always_comb onehot = en ? ({{(N-1){1'b0}}, 1'b1} << idx) : '0;
endmodule

// File: rtl/regfile_wb_buffer.sv
// regfile_wb_buffer: in-order write-back queue feeding the register array, with read bypass.
//   clk/rst              - clock, async active-low reset
//   wr_valid/wr_ready    - write-back handshake, wr_reg/wr_data request payload
//   rf_stall             - holds the head entry in the queue
//   rf_wen/rf_wdata      - one-hot row enable and shared data to the array
//   rd_regN/rd_hitN/rd_dataN - youngest queued match per read port
//   count                - occupancy
module regfile_wb_buffer
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [REG_IDX_W-1:0]     wr_reg,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rf_stall,
  output logic [NREG-1:0]          rf_wen,
  output logic [DATA_W-1:0]        rf_wdata,
  input  logic [REG_IDX_W-1:0]     rd_reg1,
  input  logic [REG_IDX_W-1:0]     rd_reg2,
  output logic                     rd_hit1,
  output logic [DATA_W-1:0]        rd_data1,
  output logic                     rd_hit2,
  output logic [DATA_W-1:0]        rd_data2,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  wb_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic push, pop;
  assign count    = count_q;
  assign wr_ready = count_q != CNT_W'(DEPTH);
  assign pop      = (count_q != '0) && !rf_stall;
  assign rf_wdata = (count_q != '0) ? mem_q[head_q].data : '0;
  // Register 0 is hardwired zero: the handshake completes but nothing is queued.
  assign push     = wr_valid && wr_ready && (wr_reg != '0);
  always_comb begin
    mem_d   = mem_q;
    valid_d = valid_q;
    if (pop) valid_d[head_q] = 1'b0;
    if (push) begin
      mem_d[tail_q]   = '{reg_idx: wr_reg, data: wr_data};
      valid_d[tail_q] = 1'b1;
    end
    head_d  = pop ? head_q + PTR_W'(1) : head_q;
    tail_d  = push ? tail_q + PTR_W'(1) : tail_q;
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q   <= '0;
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
  wb_onehot_dec #(.N(NREG), .W(REG_IDX_W)) u_dec (
    .en     (pop),
    .idx    (mem_q[head_q].reg_idx),
    .onehot (rf_wen)
  );
  // Valid entries are contiguous from head, so walking oldest to youngest and
  // letting later matches overwrite leaves the youngest match.
  function automatic logic [DATA_W:0] bypass(input logic [REG_IDX_W-1:0] rd);
    logic [PTR_W-1:0] p;
    bypass = '0;
    for (int i = 0; i < DEPTH; i++) begin
      p = head_q + PTR_W'(i);
      if (valid_q[p] && rd != '0 && mem_q[p].reg_idx == rd) bypass = {1'b1, mem_q[p].data};
    end
  endfunction
  always_comb {rd_hit1, rd_data1} = bypass(rd_reg1);
  always_comb {rd_hit2, rd_data2} = bypass(rd_reg2);
endmodule

// File: tb/tb_regfile_wb_buffer.sv
// tb_regfile_wb_buffer: directed checks of queueing, commit, bypass and reset.
module tb_regfile_wb_buffer;
  logic clk = 0, rst = 0;
  logic wr_valid = 0, wr_ready, rf_stall = 0;
  logic [3:0] wr_reg = 0, rd_reg1 = 0, rd_reg2 = 0;
  logic [15:0] wr_data = 0, rf_wen, rf_wdata, rd_data1, rd_data2;
  logic rd_hit1, rd_hit2;
  logic [2:0] count;
  int n_checks = 0, n_fail = 0;
  always #5 clk = ~clk;
  regfile_wb_buffer dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_reg(wr_reg), .wr_data(wr_data), .rf_stall(rf_stall),
    .rf_wen(rf_wen), .rf_wdata(rf_wdata), .rd_reg1(rd_reg1), .rd_reg2(rd_reg2),
    .rd_hit1(rd_hit1), .rd_data1(rd_data1), .rd_hit2(rd_hit2), .rd_data2(rd_data2),
    .count(count)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [3:0] r, input logic [15:0] d);
    wr_valid = 1; wr_reg = r; wr_data = d;
    tick();
    wr_valid = 0;
  endtask
  initial begin
    wr_valid = 1; wr_reg = 3; wr_data = 16'h1234; rd_reg1 = 3; rd_reg2 = 3;
    tick(); tick();
    check("rst_ready", wr_ready, 1);
    check("rst_count", count, 0);
    check("rst_wen", rf_wen, 0);
    check("rst_hit1", rd_hit1, 0);
    check("rst_hit2", rd_hit2, 0);
    check("rst_data1", rd_data1, 0);
    wr_valid = 0; rst = 1;
    tick();
    check("rel_count", count, 0);
    check("rel_wen", rf_wen, 0);
    push(3, 16'hBEEF);
    check("single_wen", rf_wen, 16'h0008);
    check("single_wdata", rf_wdata, 16'hBEEF);
    check("single_count", count, 1);
    check("single_hit1", rd_hit1, 1);
    check("single_data1", rd_data1, 16'hBEEF);
    tick();
    check("single_count0", count, 0);
    check("single_wen0", rf_wen, 0);
    check("single_wdata0", rf_wdata, 0);
    rf_stall = 1;
    for (int i = 1; i <= 4; i++) push(4'(i), 16'(i));
    wr_valid = 1; wr_reg = 5; wr_data = 16'h0005;
    #1;
    check("full_count", count, 4);
    check("full_ready", wr_ready, 0);
    check("full_wen_stalled", rf_wen, 0);
    tick();
    check("full_count_hold", count, 4);
    wr_valid = 0; rf_stall = 0;
    #1;
    check("drain_wen1", rf_wen, 16'h0002);
    check("drain_wdata1", rf_wdata, 16'h0001);
    tick(); check("drain_wen2", rf_wen, 16'h0004);
    tick(); check("drain_wen3", rf_wen, 16'h0008);
    tick(); check("drain_wen4", rf_wen, 16'h0010);
    check("drain_wdata4", rf_wdata, 16'h0004);
    tick(); check("drain_wen_end", rf_wen, 0);
    check("drain_count", count, 0);
    rf_stall = 1;
    push(5, 16'h1111);
    push(5, 16'h2222);
    rd_reg1 = 5; rd_reg2 = 6;
    #1;
    check("byp_hit1", rd_hit1, 1);
    check("byp_data1", rd_data1, 16'h2222);
    check("byp_hit2", rd_hit2, 0);
    check("byp_data2", rd_data2, 0);
    check("byp_count", count, 2);
    rf_stall = 0; wr_valid = 1; wr_reg = 7; wr_data = 16'h7777;
    #1;
    check("pp_wen", rf_wen, 16'h0020);
    check("pp_wdata", rf_wdata, 16'h1111);
    tick();
    wr_valid = 0;
    check("pp_count", count, 2);
    check("pp_wdata2", rf_wdata, 16'h2222);
    check("pp_hit1", rd_hit1, 1);
    check("pp_data1", rd_data1, 16'h2222);
    tick();
    check("pp_wen7", rf_wen, 16'h0080);
    check("pp_wdata7", rf_wdata, 16'h7777);
    check("pp_hit1_gone", rd_hit1, 0);
    tick();
    check("pp_count0", count, 0);
    rf_stall = 1;
    push(2, 16'hAAAA);
    wr_valid = 1; wr_reg = 0; wr_data = 16'hFFFF;
    #1;
    check("r0_ready", wr_ready, 1);
    tick();
    wr_valid = 0; rd_reg1 = 0; rd_reg2 = 2;
    #1;
    check("r0_count", count, 1);
    check("r0_hit1", rd_hit1, 0);
    check("r0_data1", rd_data1, 0);
    check("r0_hit2", rd_hit2, 1);
    check("r0_data2", rd_data2, 16'hAAAA);
    rf_stall = 0;
    #1;
    check("r0_wen", rf_wen, 16'h0004);
    tick();
    check("r0_wen_end", rf_wen, 0);
    check("r0_count0", count, 0);
    rf_stall = 1;
    push(1, 16'hA001);
    push(2, 16'hA002);
    push(3, 16'hA003);
    rf_stall = 0;
    #1;
    check("mid_wen1", rf_wen, 16'h0002);
    tick();
    check("mid_wen2", rf_wen, 16'h0004);
    #2 rst = 0;
    #1;
    check("mid_rst_wen", rf_wen, 0);
    check("mid_rst_count", count, 0);
    check("mid_rst_hit2", rd_hit2, 0);
    check("mid_rst_ready", wr_ready, 1);
    rst = 1;
    push(9, 16'h9999);
    check("post_wen", rf_wen, 16'h0200);
    check("post_wdata", rf_wdata, 16'h9999);
    check("post_count", count, 1);
    tick();
    check("post_count0", count, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
